adaptive_traffic_ctrl: RTL and testbench
========================================

ADAPTIVE_TRAFFIC_CTRL -- requirements
Module: adaptive_traffic_ctrl

Interface
REQ-001 The block SHALL expose these parameters: N_LANES, 4, number of lanes served in round-robin order (2..16).
REQ-002 The block SHALL expose these parameters: TW, 8, phase-timer width in bits.
REQ-003 The block SHALL expose these parameters: GREEN_MIN, 4, green duration in cycles without congestion (>=1).
REQ-004 The block SHALL expose these parameters: GREEN_MAX, 10, maximum green duration with congestion (>=GREEN_MIN, <2^TW).
REQ-005 The block SHALL expose these parameters: YELLOW_T, 2, yellow duration in cycles (>=1); ALLRED_T, 1, all-red clearance in cycles (>=1).
REQ-006 clk  input  1  the only clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 car_present  input  N_LANES  per-lane demand sensor, 1 = vehicles waiting.
REQ-009 congested  input  N_LANES  per-lane congestion sensor, 1 = extend green.
REQ-010 emg_req  input  1  emergency preemption request, level-sensitive.
REQ-011 emg_lane  input  LW=max(1,$clog2(N_LANES))  lane to preempt to; values >=N_LANES make emg_req ignored.
REQ-012 green  output  N_LANES  one-hot green lamp, at most one bit set.
REQ-013 yellow  output  N_LANES  one-hot yellow lamp, at most one bit set.
REQ-014 phase  output  2  2'b00 GREEN, 2'b01 YELLOW, 2'b10 ALL_RED; 2'b11 is never driven.
REQ-015 lane_idx  output  LW  lane currently owning (or last owning) the right of way.
REQ-016 timer  output  TW  cycles elapsed in the current phase, starting from 0.

Function
REQ-017 The block SHALL implement a three-state FSM, GREEN -> YELLOW -> ALL_RED -> GREEN, where timer clears to 0 on every phase change and otherwise increments by 1, saturating at 2^TW-1.
REQ-018 In GREEN, the block SHALL drive green[lane_idx]=1 and all yellow bits 0; in YELLOW, yellow[lane_idx]=1 and all green bits 0; in ALL_RED, all green and yellow bits 0.
REQ-019 GREEN SHALL exit to YELLOW at the cycle where timer>=GREEN_MIN-1 and congested[lane_idx]=0, or where timer==GREEN_MAX-1, giving a green of GREEN_MIN cycles without congestion and at most GREEN_MAX cycles with it.
REQ-020 Congestion SHALL be sampled every GREEN cycle, so deasserting congested after GREEN_MIN-1 ends the green on that cycle.
REQ-021 YELLOW SHALL last exactly YELLOW_T cycles.
REQ-022 ALL_RED SHALL last at least ALLRED_T cycles.
REQ-023 On the final ALL_RED cycle, the next lane SHALL be the first lane after lane_idx (wrapping N_LANES-1 -> 0) with car_present=1, with lane_idx itself checked last.
REQ-024 If no lane has car_present=1 on the final ALL_RED cycle, the block SHALL hold ALL_RED with timer saturating, and re-evaluate every cycle, entering GREEN on the first cycle any car_present bit is 1.
REQ-025 Preempt: with emg_req=1 and a valid emg_lane, a GREEN on a lane != emg_lane SHALL exit to YELLOW on the next edge, waiving GREEN_MIN.
REQ-026 Preempt: with emg_req=1 and a valid emg_lane, ALL_RED completion SHALL select emg_lane regardless of car_present.
REQ-027 While GREEN on emg_lane with emg_req=1, the green SHALL hold indefinitely and ignore GREEN_MAX.
REQ-028 After emg_req drops during a preempt hold, the REQ-019 exit rules SHALL apply immediately to the current timer value.
REQ-029 Emergency requests arriving during YELLOW or ALL_RED SHALL NOT shorten those phases.
REQ-030 When emg_req and demand selection coincide on the final ALL_RED cycle, emergency SHALL win.
REQ-031 Outputs SHALL be registered or decoded only from registered state, with no combinational path from any input to any output.

Reset
REQ-032 While rst_n=0, the block SHALL force phase=GREEN, lane_idx=0, timer=0, green=1 on bit 0 only, and yellow=0, asynchronously and regardless of the current phase.
REQ-033 After rst_n deasserts, the block SHALL resume normal operation on the first rising edge of clk.

Verification (N_LANES=4, GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=2, ALLRED_T=1)
REQ-034 The bench SHALL cover: car_present=4'b1111, congested=0 after reset -> lane 0 green 4 cycles, yellow 2, all-red 1, then lane 1 green; lane 0 green again at cycle 28.
REQ-035 The bench SHALL cover: congested[0]=1 held -> lane 0 green exactly 10 cycles; congested[0] dropped at timer=6 -> yellow follows cycle at timer=6 (7 green cycles).
REQ-036 The bench SHALL cover: car_present=4'b1001 -> sequence lane 0, lane 3, lane 0, with lanes 1 and 2 never green.
REQ-037 The bench SHALL cover: car_present=0 -> ALL_RED held 20+ cycles with all lamps off; car_present[2]=1 -> green[2] on the next edge.
REQ-038 The bench SHALL cover: emg_req=1, emg_lane=2 while lane 0 green at timer=1 -> yellow next edge, 2 yellow, 1 all-red, green[2] held for as long as emg_req=1 (check at 50 cycles).
REQ-039 The bench SHALL cover: rst_n pulsed low mid-YELLOW on lane 3 -> outputs immediately green=4'b0001, phase=00, timer=0.

Source files
------------

// File: rtl/adaptive_traffic_ctrl_if.sv
// Signal bundle between the traffic controller and whatever drives its sensors.
// Combinational only: no storage, no latency.
// No backpressure: sensors are level signals, and the lamp outputs are plain state.
// master: drives the sensors and emergency request, observes the lamps and status.
// slave : the controller side, the reverse of master.
interface adaptive_traffic_ctrl_if #(
  parameter int N_LANES = 4,
  parameter int TW      = 8
);
  localparam int LW = (N_LANES > 2) ? $clog2(N_LANES) : 1;

  logic [N_LANES-1:0] car_present;
  logic [N_LANES-1:0] congested;
  logic               emg_req;
  logic [LW-1:0]      emg_lane;
  logic [N_LANES-1:0] green;
  logic [N_LANES-1:0] yellow;
  logic [1:0]         phase;
  logic [LW-1:0]      lane_idx;
  logic [TW-1:0]      timer;

  modport master (
    output car_present, congested, emg_req, emg_lane,
    input  green, yellow, phase, lane_idx, timer
  );

  modport slave (
    input  car_present, congested, emg_req, emg_lane,
    output green, yellow, phase, lane_idx, timer
  );
endinterface

// File: rtl/adaptive_traffic_ctrl.sv
// Round-robin traffic light controller with congestion extension and emergency preemption.
// Lamps and status decode from registered state only, so an input change shows one edge later.
// No backpressure: sensors are sampled every cycle, and the lamps always reflect the current phase.
// Ports: clk, rst_n (async, active low); bus (slave) carries car_present, congested, emg_req,
//        and emg_lane in, and green, yellow, phase, lane_idx, and timer out.
module adaptive_traffic_ctrl #(
  parameter int N_LANES   = 4,
  parameter int TW        = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  adaptive_traffic_ctrl_if.slave bus
);
  localparam int LW    = (N_LANES > 2) ? $clog2(N_LANES) : 1;
  localparam int NSLOT = 1 << LW;
  // One bit per encodable lane number, set only for lanes that exist.
  localparam logic [NSLOT-1:0] LANE_OK = NSLOT'((64'd1 << N_LANES) - 64'd1);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_e;

  phase_e        state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          emg_valid;
  logic [31:0]   elapsed;     // cycles spent in this phase, counting the current one
  logic          rr_found;
  logic [LW-1:0] rr_lane;
  logic          green_exit;

  assign emg_valid = bus.emg_req && LANE_OK[bus.emg_lane];
  assign elapsed   = 32'(timer_q) + 32'd1;

  // Search for the next lane with demand. Walk from the farthest candidate to the nearest
  // so the nearest one after lane_q wins; lane_q itself (k = N_LANES) is the last resort.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_lane  = lane_q;
    for (int k = N_LANES; k >= 1; k--) begin
      idx = (int'(lane_q) + k) % N_LANES;
      if (bus.car_present[idx]) begin
        rr_found = 1'b1;
        rr_lane  = LW'(idx);
      end
    end
  end

  // A preempt on another lane ends the green at once. A preempt on this lane holds it.
  // Otherwise the normal minimum and congestion rules apply. The ">=" on GREEN_MAX catches
  // a timer that ran past the limit during an emergency hold.
  always_comb begin
    green_exit = 1'b0;
    if (emg_valid) begin
      green_exit = (bus.emg_lane != lane_q);
    end else begin
      green_exit = ((elapsed >= 32'(GREEN_MIN)) && !bus.congested[lane_q]) ||
                   (elapsed >= 32'(GREEN_MAX));
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    case (state_q)
      PH_GREEN: begin
        if (green_exit) state_d = PH_YELLOW;
      end
      PH_YELLOW: begin
        if (elapsed >= 32'(YELLOW_T)) state_d = PH_ALLRED;
      end
      PH_ALLRED: begin
        // Once the minimum clearance is met, keep re-evaluating every cycle until
        // there is somewhere to go. An emergency overrides demand.
        if (elapsed >= 32'(ALLRED_T)) begin
          if (emg_valid) begin
            state_d = PH_GREEN;
            lane_d  = bus.emg_lane;
          end else if (rr_found) begin
            state_d = PH_GREEN;
            lane_d  = rr_lane;
          end
        end
      end
      default: state_d = PH_GREEN;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_GREEN;
      lane_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      timer_q <= timer_d;
    end
  end

  logic [N_LANES-1:0] green_w, yellow_w;

  always_comb begin
    green_w  = '0;
    yellow_w = '0;
    if (state_q == PH_GREEN)  green_w[lane_q]  = 1'b1;
    if (state_q == PH_YELLOW) yellow_w[lane_q] = 1'b1;
  end

  assign bus.green    = green_w;
  assign bus.yellow   = yellow_w;
  assign bus.phase    = state_q;
  assign bus.lane_idx = lane_q;
  assign bus.timer    = timer_q;
endmodule

// File: tb/tb_adaptive_traffic_ctrl.sv
// Self-checking bench for adaptive_traffic_ctrl (N_LANES=4, TW=8, GREEN_MIN=4, GREEN_MAX=10,
// YELLOW_T=2, ALLRED_T=1). Inputs change on the falling edge, and outputs are sampled there too.
// Each vector holds its inputs for 'adv' rising edges, then checks phase, lane, timer, and lamps.
module tb_adaptive_traffic_ctrl;
  logic clk;
  logic rst_n;

  adaptive_traffic_ctrl_if #(.N_LANES(4), .TW(8)) bus ();

  adaptive_traffic_ctrl #(
    .N_LANES(4), .TW(8), .GREEN_MIN(4), .GREEN_MAX(10), .YELLOW_T(2), .ALLRED_T(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] car;
    logic [3:0] cong;
    logic       er;
    logic [1:0] el;
    logic       w12;   // lanes 1 and 2 must stay dark while this is set
    int         adv;
    logic [1:0] ph;
    logic [1:0] ln;
    logic [7:0] tm;
  } vec_t;

  typedef struct {
    int         id;
    logic [1:0] ph;
    logic [1:0] ln;
    logic [7:0] tm;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic watch12 = 1'b0;
  logic seen12  = 1'b0;
  logic bad_inv = 1'b0;

  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10;

  function automatic vec_t mk(input logic [3:0] car, input logic [3:0] cong, input logic er,
                              input logic [1:0] el, input logic w12, input int adv,
                              input logic [1:0] ph, input logic [1:0] ln, input logic [7:0] tm);
    vec_t v;
    v.car = car; v.cong = cong; v.er = er; v.el = el; v.w12 = w12; v.adv = adv;
    v.ph = ph; v.ln = ln; v.tm = tm;
    return v;
  endfunction

  // Pop the oldest expectation and compare it against what the DUT shows right now.
  task automatic check_out();
    exp_t       e;
    logic [3:0] eg, ey;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: queue empty, DUT output has no matching expectation");
      return;
    end
    e  = exp_q.pop_front();
    eg = (e.ph == G) ? (4'b0001 << e.ln) : 4'b0000;
    ey = (e.ph == Y) ? (4'b0001 << e.ln) : 4'b0000;
    n_vec++;
    if (bus.phase !== e.ph || bus.lane_idx !== e.ln || bus.timer !== e.tm ||
        bus.green !== eg || bus.yellow !== ey) begin
      n_bad++;
      $display("FAIL vec%0d: got phase=%0d lane=%0d timer=%0d green=%b yellow=%b, want phase=%0d lane=%0d timer=%0d green=%b yellow=%b",
               e.id, bus.phase, bus.lane_idx, bus.timer, bus.green, bus.yellow,
               e.ph, e.ln, e.tm, eg, ey);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    bus.car_present = v.car;
    bus.congested   = v.cong;
    bus.emg_req     = v.er;
    bus.emg_lane    = v.el;
    watch12         = v.w12;
    e.id = id; e.ph = v.ph; e.ln = v.ln; e.tm = v.tm;
    exp_q.push_back(e);
    repeat (v.adv) @(posedge clk);
    if (v.adv > 0) @(negedge clk);
    check_out();
  endtask

  // Continuous checks for lamp exclusivity, legal phase encoding, and the lane-1/2 watch window.
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(bus.green) > 1 || $countones(bus.yellow) > 1 || bus.phase == 2'b11 ||
          (bus.green != 4'b0 && bus.yellow != 4'b0))
        bad_inv = 1'b1;
      if (watch12 && (bus.green[1] || bus.green[2]))
        seen12 = 1'b1;
    end
  end

  initial begin
    exp_t e;
    // Round robin with all lanes busy and no congestion; lane 0 returns at edge 28.
    tbl.push_back(mk(4'b1111, 4'b0000, 0, 0, 0, 0, G, 0, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 0, 0, 0, 3, G, 0, 3));
    tbl.push_back(mk(4'b1111, 4'b0000, 0, 0, 0, 1, Y, 0, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 0, 0, 0, 1, Y, 0, 1));
    tbl.push_back(mk(4'b1111, 4'b0000, 0, 0, 0, 1, R, 0, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 0, 0, 0, 1, G, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 0, 0, 0, 7, G, 2, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 0, 0, 0, 7, G, 3, 0));
    tbl.push_back(mk(4'b1111, 4'b0000, 0, 0, 0, 7, G, 0, 0));
    // Congestion held on lane 0: the green lasts exactly 10 cycles.
    tbl.push_back(mk(4'b1111, 4'b0001, 0, 0, 0, 9, G, 0, 9));
    tbl.push_back(mk(4'b1111, 4'b0001, 0, 0, 0, 1, Y, 0, 0));
    tbl.push_back(mk(4'b1111, 4'b0001, 0, 0, 0, 3, G, 1, 0));
    tbl.push_back(mk(4'b1111, 4'b0001, 0, 0, 0, 21, G, 0, 0));
    // Congestion dropped while timer=6: yellow on the next edge.
    tbl.push_back(mk(4'b1111, 4'b0001, 0, 0, 0, 6, G, 0, 6));
    tbl.push_back(mk(4'b1111, 4'b0000, 0, 0, 0, 1, Y, 0, 0));
    // Demand only on lanes 0 and 3: they alternate.
    tbl.push_back(mk(4'b1001, 4'b0000, 0, 0, 1, 3, G, 3, 0));
    tbl.push_back(mk(4'b1001, 4'b0000, 0, 0, 1, 7, G, 0, 0));
    tbl.push_back(mk(4'b1001, 4'b0000, 0, 0, 1, 7, G, 3, 0));
    // No demand: hold all-red, the timer saturates, and the first car is served on the next edge.
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 6, R, 3, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 22, R, 3, 22));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 240, R, 3, 255));
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 0, 0, 1, G, 2, 0));
    // Emergency to lane 2 while lane 0 is green at timer=1.
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, 7, G, 0, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, 1, G, 0, 1));
    tbl.push_back(mk(4'b0001, 4'b0000, 1, 2, 0, 1, Y, 0, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 1, 2, 0, 1, Y, 0, 1));
    tbl.push_back(mk(4'b0001, 4'b0000, 1, 2, 0, 1, R, 0, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 1, 2, 0, 1, G, 2, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 1, 2, 0, 50, G, 2, 50));
    tbl.push_back(mk(4'b0001, 4'b0000, 0, 2, 0, 1, Y, 2, 0));
    // Run on to a yellow on lane 3, ready for the mid-yellow reset.
    tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 7, Y, 3, 0));

    rst_n           = 1'b0;
    bus.car_present = 4'b1111;
    bus.congested   = 4'b0000;
    bus.emg_req     = 1'b0;
    bus.emg_lane    = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Asynchronous reset in the middle of the lane-3 yellow, checked before any clock edge.
    #2 rst_n = 1'b0;
    e.id = 100; e.ph = G; e.ln = 0; e.tm = 0;
    exp_q.push_back(e);
    #1 check_out();
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(4'b1111, 4'b0000, 0, 0, 0, 1, G, 0, 1), 101);
    apply(mk(4'b1111, 4'b0000, 0, 0, 0, 3, Y, 0, 0), 102);

    n_vec++;
    if (seen12 !== 1'b0) begin
      n_bad++;
      $display("FAIL lanes12_dark: green seen on lane 1 or 2 = %b, want 0", seen12);
    end
    n_vec++;
    if (bad_inv !== 1'b0) begin
      n_bad++;
      $display("FAIL lamp_invariant: violation flag = %b, want 0", bad_inv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
